io_pi_core_capture: RTL and testbench

- Input-direction counterpart of the fabric-to-SoC output pad tile. It carries a SoC-driven input pad signal into the FPGA fabric.
- Samples the asynchronous pad input through a two-flop synchronizer. Applies optional inversion and a programmable glitch filter.
- Presents the committed level to the fabric, plus one-cycle rise/fall pulses and a sticky event flag.
- Sits between the gfpga_pad_pinput_A2F global input port and the io_pi_core_inpad fabric pin of the io_pi logical tile.

---
 rtl/io_pi_core_capture.sv | 65 ++++++
 tb/tb_io_pi_core_capture.sv | 119 +++++++++++
 2 files changed

// File: rtl/io_pi_core_capture.sv
// io_pi_core_capture: synchronize, optionally invert and glitch-filter a SoC pad input for the fabric
// Ports: clk, resetn (async assert, active-low); gfpga_pad_pinput_A2F async pad input;
//   cfg_invert / cfg_filter_en / cfg_filter_len filter setup; evt_clr clears the sticky flag;
//   io_pi_core_inpad committed level, io_pi_core_rise / io_pi_core_fall one-cycle commit pulses,
//   io_pi_core_evt sticky change flag.
module io_pi_core_capture #(
  parameter int   CNT_W     = 4,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             gfpga_pad_pinput_A2F,
  input  logic             cfg_invert,
  input  logic             cfg_filter_en,
  input  logic [CNT_W-1:0] cfg_filter_len,
  input  logic             evt_clr,
  output logic             io_pi_core_inpad,
  output logic             io_pi_core_rise,
  output logic             io_pi_core_fall,
  output logic             io_pi_core_evt
);
  typedef enum logic {STABLE, PENDING} state_t;
  state_t state, state_n;
  logic s1, s2, d, commit;
  logic [CNT_W-1:0] cnt, cnt_n, eff_len;
  assign d = s2 ^ cfg_invert;
  assign eff_len = cfg_filter_en ? cfg_filter_len : '0;
  always_comb begin
    state_n = state;
    cnt_n = '0;
    commit = 1'b0;
    if (state == STABLE) begin
      if (d != io_pi_core_inpad) begin
        commit = eff_len == '0;
        state_n = commit ? STABLE : PENDING;
        cnt_n = commit ? '0 : CNT_W'(1);
      end
    end else begin
      commit = d != io_pi_core_inpad && cnt >= eff_len;
      state_n = (d == io_pi_core_inpad || commit) ? STABLE : PENDING;
      cnt_n = state_n == PENDING ? cnt + CNT_W'(1) : '0;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
      state <= STABLE;
      cnt <= '0;
      io_pi_core_inpad <= RESET_VAL;
      io_pi_core_rise <= 1'b0;
      io_pi_core_fall <= 1'b0;
      io_pi_core_evt <= 1'b0;
    end else begin
      s1 <= gfpga_pad_pinput_A2F;
      s2 <= s1;
      state <= state_n;
      cnt <= cnt_n;
      io_pi_core_inpad <= commit ? d : io_pi_core_inpad;
      io_pi_core_rise <= commit & d;
      io_pi_core_fall <= commit & ~d;
      io_pi_core_evt <= commit | (io_pi_core_evt & ~evt_clr);
    end
  end
endmodule

// File: tb/tb_io_pi_core_capture.sv
// tb_io_pi_core_capture: scoreboard bench for io_pi_core_capture against a run-length reference model
module tb_io_pi_core_capture;
  localparam int CNT_W = 4;
  localparam logic RV = 1'b0;
  typedef struct packed {logic inpad; logic rise; logic fall; logic evt;} exp_t;
  logic clk = 0, resetn = 0, pad = 0, inv = 0, en = 0, clr = 0;
  logic [CNT_W-1:0] len = '0;
  logic inpad, rise, fall, evt;
  exp_t q[$];
  int total = 0, bad = 0;
  logic m_p1 = RV, m_p2 = RV, m_in = RV, m_evt = 0;
  int m_run = 0;
  io_pi_core_capture #(.CNT_W(CNT_W), .RESET_VAL(RV)) dut (
    .clk(clk), .resetn(resetn), .gfpga_pad_pinput_A2F(pad), .cfg_invert(inv),
    .cfg_filter_en(en), .cfg_filter_len(len), .evt_clr(clr),
    .io_pi_core_inpad(inpad), .io_pi_core_rise(rise), .io_pi_core_fall(fall), .io_pi_core_evt(evt)
  );
  always #5 clk = ~clk;
  // Reference: a change commits once the synchronized, inverted value has differed from the
  // committed level for more than L consecutive samples, L being the length in force at that sample.
  task automatic model_push();
    logic dm, cm;
    int l;
    if (!resetn) begin
      m_p1 = RV; m_p2 = RV; m_in = RV; m_evt = 0; m_run = 0;
      q.push_back({RV, 1'b0, 1'b0, 1'b0});
    end else begin
      dm = m_p2 ^ inv;
      l = en ? int'(len) : 0;
      m_run = (dm != m_in) ? m_run + 1 : 0;
      cm = m_run > l;
      if (cm) begin
        m_in = dm;
        m_run = 0;
      end
      m_evt = cm | (m_evt & ~clr);
      q.push_back({m_in, cm & dm, cm & ~dm, m_evt});
      m_p2 = m_p1;
      m_p1 = pad;
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      model_push();
      @(negedge clk);
    end
  endtask
  task automatic chk(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", name, got, want, $time);
    end
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      total++;
      if ({inpad, rise, fall, evt} !== e) begin
        bad++;
        $display("FAIL scoreboard got inpad/rise/fall/evt=%b want=%b t=%0t", {inpad, rise, fall, evt}, e, $time);
      end
    end
  end
  initial begin
    @(negedge clk);
    chk("reset_inpad", inpad, RV);
    chk("reset_evt", evt, 1'b0);
    tick(2);
    resetn = 1; pad = 1;
    tick(2); chk("t1_latency_early", inpad, 1'b0);
    tick(1); chk("t1_inpad", inpad, 1'b1); chk("t1_rise", rise, 1'b1); chk("t1_evt", evt, 1'b1);
    tick(1); chk("t1_rise_once", rise, 1'b0);
    pad = 0; tick(4); chk("t1_back_low", inpad, 1'b0);
    clr = 1; tick(1); clr = 0; chk("t1_evt_clr", evt, 1'b0);
    en = 1; len = 3; pad = 1; tick(3); pad = 0; tick(6);
    chk("t2_glitch_inpad", inpad, 1'b0); chk("t2_glitch_evt", evt, 1'b0);
    pad = 1; tick(5); chk("t2_before_commit", inpad, 1'b0);
    tick(1); chk("t2_commit", inpad, 1'b1); chk("t2_rise", rise, 1'b1);
    tick(3);
    en = 0; pad = 0; tick(2); clr = 1;
    tick(1); chk("t3_inpad", inpad, 1'b0); chk("t3_fall", fall, 1'b1); chk("t3_evt_set_wins", evt, 1'b1);
    tick(1); chk("t3_evt_cleared", evt, 1'b0); clr = 0;
    en = 1; len = 2; inv = 1;
    tick(2); chk("t4_early", inpad, 1'b0);
    tick(1); chk("t4_inv_commit", inpad, 1'b1); chk("t4_rise", rise, 1'b1);
    inv = 0; tick(4); chk("t4_inv_back", inpad, 1'b0);
    len = 5; pad = 1; tick(4); len = 1;
    tick(1); chk("t5_len_lowered", inpad, 1'b1);
    len = 3; pad = 0; tick(4);
    resetn = 0; #1;
    chk("t6_async_inpad", inpad, RV); chk("t6_async_evt", evt, 1'b0);
    chk("t6_async_rise", rise, 1'b0); chk("t6_async_fall", fall, 1'b0);
    chk("t6_async_s1", dut.s1, RV); chk("t6_async_s2", dut.s2, RV);
    tick(2); resetn = 1; pad = 1;
    tick(5); chk("t6_post_early", inpad, 1'b0);
    tick(1); chk("t6_post_commit", inpad, 1'b1); chk("t6_post_rise", rise, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) pad = ~pad;
      if ($urandom_range(63) == 0) len = CNT_W'($urandom_range(5));
      if ($urandom_range(49) == 0) en = ~en;
      if ($urandom_range(99) == 0) inv = ~inv;
      clr = $urandom_range(15) == 0;
      resetn = $urandom_range(499) != 0;
      tick(1);
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
